// File: rtl/demux_scan_ctrl.sv
// Upstream driver for a 1-to-7 demux: latches a data word and channel mask, then
// walks the enabled channels in ascending order, holding each on Sel/D for HOLD_CYCLES clocks.
module demux_scan_ctrl #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [2:0]  IDLE_SEL    = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_data,
  input  logic [6:0] in_mask,
  output logic [2:0] Sel,
  output logic       D,
  output logic       busy,
  output logic       done
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, so the upstream holds its word stable until then.
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t     state_q, state_d;
  logic [6:0] data_q, data_d;
  logic [6:0] mask_q, mask_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic       d_q, d_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [2:0] first_idx;
  logic [2:0] nxt_idx;
  logic       nxt_found;

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  assign in_ready = (state_q == ST_IDLE);
  assign Sel      = sel_q;
  assign D        = d_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Descending loops leave the lowest qualifying index as the final assignment.
  always_comb begin
    first_idx = 3'd0;
    nxt_idx   = 3'd0;
    nxt_found = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (in_mask[i]) first_idx = 3'(i);
      if (mask_q[i] && (3'(i) > idx_q)) begin
        nxt_idx   = 3'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    d_d     = d_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d  = IDLE_SEL;
        d_d    = 1'b0;
        busy_d = 1'b0;
        if (in_valid) begin
          data_d = in_data;
          mask_d = in_mask;
          cnt_d  = 8'd0;
          if (in_mask != 7'd0) begin
            state_d = ST_SCAN;
            idx_d   = first_idx;
            sel_d   = first_idx;
            d_d     = in_data[first_idx];
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = 8'd0;
          if (nxt_found) begin
            idx_d = nxt_idx;
            sel_d = nxt_idx;
            d_d   = data_q[nxt_idx];
          end else begin
            state_d = ST_DONE;
            sel_d   = IDLE_SEL;
            d_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sel_d   = IDLE_SEL;
        d_d     = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = IDLE_SEL;
        d_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= 7'd0;
      mask_q  <= 7'd0;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      sel_q   <= IDLE_SEL;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Bench for demux_scan_ctrl: two instances (hold 1 and hold 3) checked cycle by cycle
// against an expected-output queue built from the channel walk rules.
module tb_demux_scan_ctrl;

  localparam int H0 = 1;
  localparam int H1 = 3;

  logic       clk;
  logic       rst_n;
  logic       in_valid [2];
  logic [6:0] in_data  [2];
  logic [6:0] in_mask  [2];
  logic       in_ready [2];
  logic [2:0] sel      [2];
  logic       d_out    [2];
  logic       busy     [2];
  logic       done     [2];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [5:0] exp_q[$];

  demux_scan_ctrl #(.HOLD_CYCLES(H0), .IDLE_SEL(3'd7)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_mask(in_mask[0]), .Sel(sel[0]), .D(d_out[0]),
    .busy(busy[0]), .done(done[0]));

  demux_scan_ctrl #(.HOLD_CYCLES(H1), .IDLE_SEL(3'd7)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_mask(in_mask[1]), .Sel(sel[1]), .D(d_out[1]),
    .busy(busy[1]), .done(done[1]));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, "_sel"},   32'(sel[u]),      32'd7);
    check({tag, "_d"},     32'(d_out[u]),    32'd0);
    check({tag, "_busy"},  32'(busy[u]),     32'd0);
    check({tag, "_done"},  32'(done[u]),     32'd0);
    check({tag, "_ready"}, 32'(in_ready[u]), 32'd1);
  endtask

  // Driver: wait (bounded) for in_ready, present the word, let the accept edge pass.
  task automatic start(input int u, input logic [6:0] data, input logic [6:0] mask);
    for (int k = 0; k < 100 && !in_ready[u]; k++) tick();
    check("ready_wait", 32'(in_ready[u]), 32'd1);
    in_valid[u] = 1'b1;
    in_data[u]  = data;
    in_mask[u]  = mask;
    tick();
  endtask

  // Reference: each enabled channel n, ascending, appears for hold clocks with D = data[n],
  // then one idle-select cycle with done high.
  task automatic build_exp(input int u, input logic [6:0] data, input logic [6:0] mask);
    int h;
    h = (u == 0) ? H0 : H1;
    exp_q.delete();
    for (int n = 0; n < 7; n++)
      if (mask[n])
        for (int c = 0; c < h; c++) exp_q.push_back({3'(n), data[n], 1'b1, 1'b0});
    exp_q.push_back({3'd7, 1'b0, 1'b0, 1'b1});
  endtask

  // Scoreboard: compare every cycle from the one after the accept edge through DONE.
  task automatic expect_scan(input int u, input logic [6:0] data, input logic [6:0] mask,
                             input string tag);
    logic [5:0] e;
    build_exp(u, data, mask);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_sel"},   32'(sel[u]),      32'(e[5:3]));
      check({tag, "_d"},     32'(d_out[u]),    32'(e[2]));
      check({tag, "_busy"},  32'(busy[u]),     32'(e[1]));
      check({tag, "_done"},  32'(done[u]),     32'(e[0]));
      check({tag, "_ready"}, 32'(in_ready[u]), 32'd0);
      tick();
    end
    check({tag, "_post_ready"}, 32'(in_ready[u]), 32'd1);
    check({tag, "_post_sel"},   32'(sel[u]),      32'd7);
    check({tag, "_post_done"},  32'(done[u]),     32'd0);
  endtask

  task automatic run(input int u, input logic [6:0] data, input logic [6:0] mask,
                     input string tag);
    start(u, data, mask);
    in_valid[u] = 1'b0;
    expect_scan(u, data, mask, tag);
  endtask

  initial begin
    logic [6:0] a_data, a_mask, b_data, b_mask;
    int guard;

    // Reset with inputs active: they must be ignored.
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b1;
      in_data[u]  = 7'h55;
      in_mask[u]  = 7'h7F;
    end
    tick();
    tick();
    for (int u = 0; u < 2; u++) begin
      check("rst_sel",  32'(sel[u]),   32'd7);
      check("rst_busy", 32'(busy[u]),  32'd0);
      check("rst_done", 32'(done[u]),  32'd0);
      in_valid[u] = 1'b0;
    end
    rst_n = 1'b1;
    tick();
    check_idle(0, "post_rst0");
    check_idle(1, "post_rst1");

    // Directed cases.
    run(0, 7'b1010101, 7'h7F, "full_h1");
    run(1, 7'h7F, 7'b1000101, "sparse_h3");
    run(0, 7'h2A, 7'h00, "empty_h1");
    run(1, 7'h13, 7'h00, "empty_h3");
    run(0, 7'h3C, 7'h40, "top_only");
    run(1, 7'h01, 7'h01, "bottom_only");

    // Back-pressure: second word waits behind the first scan on each instance.
    for (int u = 0; u < 2; u++) begin
      a_data = 7'($urandom);
      a_mask = 7'($urandom_range(1, 127));
      b_data = 7'($urandom);
      b_mask = 7'($urandom_range(1, 127));
      start(u, a_data, a_mask);
      in_data[u] = b_data;
      in_mask[u] = b_mask;
      expect_scan(u, a_data, a_mask, "bp_first");
      tick();
      in_valid[u] = 1'b0;
      in_data[u]  = ~b_data;
      in_mask[u]  = ~b_mask;
      expect_scan(u, b_data, b_mask, "bp_second");
    end

    // Random words.
    for (int k = 0; k < 16; k++) begin
      run(k % 2, 7'($urandom), 7'($urandom_range(0, 127)), "rand");
    end

    // Mid-scan reset while channel 3 is on the bus.
    start(1, 7'h7F, 7'h7F);
    in_valid[1] = 1'b0;
    guard = 0;
    while (sel[1] != 3'd3 && guard < 40) begin
      tick();
      guard++;
    end
    check("mid_reach_sel3", 32'(sel[1]), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_sel",  32'(sel[1]),  32'd7);
    check("mid_rst_d",    32'(d_out[1]), 32'd0);
    check("mid_rst_busy", 32'(busy[1]), 32'd0);
    tick();
    check("mid_rst_done", 32'(done[1]), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("mid_no_done", 32'(done[1]), 32'd0);
      tick();
    end
    check_idle(1, "mid_idle");
    run(1, 7'b0101100, 7'b0110100, "after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
